axi_stream_header_arbiter: RTL

Round-robin arbiter that shares one axi_stream_insert_header instance among NUM_SRC requesters. Each requester offers a header (insert channel) and a payload packet (data channel). The arbiter grants one source, forwards its header, then forwards its payload until last_in is accepted, then re-arbitrates. It sits directly upstream of axi_stream_insert_header.

---
 rtl/axi_hdr_arb_pkg.sv | 18 +
 rtl/axi_hdr_rr_pick.sv | 34 +++
 rtl/axi_stream_header_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/axi_hdr_arb_pkg.sv
// Shared types and helpers for the header/payload round-robin arbiter.
// FSM encoding, packet counter width and round-robin pointer advance.
package axi_hdr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int PKT_CNT_WD = 16;

    // Explicit wrap so NUM_SRC need not be a power of two.
    function automatic int ptr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/axi_hdr_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// Zero latency; no flow control of its own.
module axi_hdr_rr_pick #(
    parameter int NUM_SRC = 2,
    parameter int SRC_WD  = 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_WD-1:0]  ptr_i,
    output logic [NUM_SRC-1:0] gnt_oh_o,
    output logic [SRC_WD-1:0]  gnt_idx_o,
    output logic               any_req_o
);

    // Each requester's distance from the pointer; the smallest distance wins.
    always_comb begin
        int best;
        int d;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        best      = NUM_SRC;
        for (int i = 0; i < NUM_SRC; i++) begin
            d = i - int'(ptr_i);
            if (d < 0) d = d + NUM_SRC;
            if (req_i[i] && d < best) begin
                best        = d;
                gnt_oh_o    = '0;
                gnt_oh_o[i] = 1'b1;
                gnt_idx_o   = SRC_WD'(i);
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin share of one header inserter: grant, forward header, forward payload to last, re-arbitrate.
// Zero-latency muxes, one IDLE cycle per packet; non-owners see ready=0. AXI_HDR_ARB_PKT_CNT_EN adds pkt_cnt.
module axi_stream_header_arbiter
    import axi_hdr_arb_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = 2,
    parameter int SRC_WD       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
    output logic [NUM_SRC-1:0]              s_ready_insert,
    input  logic [NUM_SRC-1:0]              s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
    input  logic [NUM_SRC-1:0]              s_last_in,
    output logic [NUM_SRC-1:0]              s_ready_in,
    output logic                            m_valid_insert,
    output logic [DATA_WD-1:0]              m_data_insert,
    output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
    output logic [BYTE_CNT_WD-1:0]          m_byte_insert_cnt,
    input  logic                            m_ready_insert,
    output logic                            m_valid_in,
    output logic [DATA_WD-1:0]              m_data_in,
    output logic [DATA_BYTE_WD-1:0]         m_keep_in,
    output logic                            m_last_in,
    input  logic                            m_ready_in,
    output logic [SRC_WD-1:0]               grant_idx,
    output logic                            busy
`ifdef AXI_HDR_ARB_PKT_CNT_EN
   ,output logic [NUM_SRC*PKT_CNT_WD-1:0]   pkt_cnt
`endif
);

    state_e               state_q;
    logic [SRC_WD-1:0]    ptr_q;
    logic [SRC_WD-1:0]    grant_q;
    logic [NUM_SRC-1:0]   gnt_oh_q;
    logic                 busy_q;

    logic [NUM_SRC-1:0]   pick_oh;
    logic [SRC_WD-1:0]    pick_idx;
    logic                 pick_any;
    logic                 in_hdr;
    logic                 in_data;
    logic                 hdr_hs;
    logic                 last_hs;

    axi_hdr_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_WD  (SRC_WD)
    ) u_pick (
        .req_i     (s_valid_insert),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_req_o (pick_any)
    );

    assign in_hdr  = (state_q == HDR);
    assign in_data = (state_q == DATA);

    assign m_valid_insert    = in_hdr & s_valid_insert[grant_q];
    assign m_data_insert     = in_hdr ? s_data_insert[grant_q*DATA_WD +: DATA_WD] : '0;
    assign m_keep_insert     = in_hdr ? s_keep_insert[grant_q*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
    assign m_byte_insert_cnt = in_hdr ? s_byte_insert_cnt[grant_q*BYTE_CNT_WD +: BYTE_CNT_WD] : '0;
    assign s_ready_insert    = (in_hdr & m_ready_insert) ? gnt_oh_q : '0;

    assign m_valid_in = in_data & s_valid_in[grant_q];
    assign m_data_in  = in_data ? s_data_in[grant_q*DATA_WD +: DATA_WD] : '0;
    assign m_keep_in  = in_data ? s_keep_in[grant_q*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
    assign m_last_in  = in_data & s_last_in[grant_q];
    assign s_ready_in = (in_data & m_ready_in) ? gnt_oh_q : '0;

    assign hdr_hs  = m_valid_insert & m_ready_insert;
    assign last_hs = m_valid_in & m_ready_in & m_last_in;

    assign grant_idx = grant_q;
    assign busy      = busy_q;

    // Grant is only re-evaluated in IDLE; a header valid dropping in HDR just stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (pick_any) begin
                    grant_q  <= pick_idx;
                    gnt_oh_q <= pick_oh;
                    busy_q   <= 1'b1;
                    state_q  <= HDR;
                end
                HDR: if (hdr_hs) state_q <= DATA;
                DATA: if (last_hs) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= SRC_WD'(ptr_next(int'(grant_q), NUM_SRC));
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXI_HDR_ARB_PKT_CNT_EN
    logic [PKT_CNT_WD-1:0] cnt_q [NUM_SRC];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
        end else if (last_hs) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
        assign pkt_cnt[gi*PKT_CNT_WD +: PKT_CNT_WD] = cnt_q[gi];
    end
`endif

endmodule
